// File: rtl/writeback_arbiter_if.sv
// Lane result handshake plus register-file write port of the writeback arbiter.
// master is the arbiter side; slave is the lanes / register file side.
interface writeback_arbiter_if #(
  parameter int unsigned LANES  = 2,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 3
);
  logic [LANES-1:0]        res_valid;
  logic [LANES-1:0]        res_ready;
  logic [LANES*ADDR_W-1:0] res_addr;
  logic [LANES*DATA_W-1:0] res_data;
  logic                    wr_en;
  logic [ADDR_W-1:0]       wr_addr;
  logic [DATA_W-1:0]       wr_data;
  logic [2**ADDR_W-1:0]    busy;
  logic                    idle;

  modport master (
    input  res_valid, res_addr, res_data,
    output res_ready, wr_en, wr_addr, wr_data, busy, idle
  );

  modport slave (
    output res_valid, res_addr, res_data,
    input  res_ready, wr_en, wr_addr, wr_data, busy, idle
  );
endinterface

// File: rtl/writeback_arbiter.sv
// Per-lane result FIFOs drained round-robin into a registered register-file write port,
// with a per-register pending bitmap for the issue stage.
module writeback_arbiter #(
  parameter int unsigned LANES  = 2,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 3
) (
  input  logic                clk,
  input  logic                rst,
  writeback_arbiter_if.master bus
);

  localparam int unsigned PtrW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW    = $clog2(DEPTH + 1);
  localparam int unsigned LaneW   = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned NumRegs = 2 ** ADDR_W;

  logic [ADDR_W-1:0] addr_q  [LANES][DEPTH];
  logic [DATA_W-1:0] data_q  [LANES][DEPTH];
  logic [PtrW-1:0]   wptr_q  [LANES];
  logic [PtrW-1:0]   rptr_q  [LANES];
  logic [CntW-1:0]   count_q [LANES];
  logic [LaneW-1:0]  rr_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;

  logic [LANES-1:0]   ready;
  logic [LANES-1:0]   push;
  logic [LANES-1:0]   pop;
  logic               gnt_valid;
  logic [LaneW-1:0]   gnt;
  logic [LaneW-1:0]   cand;
  logic [LaneW-1:0]   rr_next;
  logic [PtrW-1:0]    off;
  logic [NumRegs-1:0] busy;
  logic               idle;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    // Ready looks only at the count so a full FIFO never relies on a same-cycle pop.
    assign ready[i] = !rst && (count_q[i] != CntW'(DEPTH));
    assign push[i]  = bus.res_valid[i] && ready[i];
    assign pop[i]   = gnt_valid && (gnt == LaneW'(i));
  end

  // First non-empty lane at or after rr_q, wrapping.
  always_comb begin
    gnt_valid = 1'b0;
    gnt       = '0;
    cand      = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      cand = LaneW'((32'(rr_q) + k) % LANES);
      if (!gnt_valid && (count_q[cand] != '0)) begin
        gnt_valid = 1'b1;
        gnt       = cand;
      end
    end
  end

  assign rr_next = (gnt == LaneW'(LANES - 1)) ? '0 : gnt + LaneW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LANES; i++) begin
        wptr_q[i]  <= '0;
        rptr_q[i]  <= '0;
        count_q[i] <= '0;
      end
      rr_q      <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (push[i]) begin
          addr_q[i][wptr_q[i]] <= bus.res_addr[i*ADDR_W +: ADDR_W];
          data_q[i][wptr_q[i]] <= bus.res_data[i*DATA_W +: DATA_W];
          wptr_q[i]            <= wptr_q[i] + PtrW'(1);
        end
        if (pop[i]) begin
          rptr_q[i] <= rptr_q[i] + PtrW'(1);
        end
        case ({push[i], pop[i]})
          2'b10:   count_q[i] <= count_q[i] + CntW'(1);
          2'b01:   count_q[i] <= count_q[i] - CntW'(1);
          default: count_q[i] <= count_q[i];
        endcase
      end
      wr_en_q <= gnt_valid;
      if (gnt_valid) begin
        wr_addr_q <= addr_q[gnt][rptr_q[gnt]];
        wr_data_q <= data_q[gnt][rptr_q[gnt]];
        rr_q      <= rr_next;
      end
    end
  end

  // An entry is live when its distance from the read pointer is below the count.
  always_comb begin
    busy = '0;
    off  = '0;
    for (int i = 0; i < LANES; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        off = PtrW'(j) - rptr_q[i];
        if (CntW'(off) < count_q[i]) begin
          busy[addr_q[i][j]] = 1'b1;
        end
      end
    end
    if (wr_en_q) begin
      busy[wr_addr_q] = 1'b1;
    end
  end

  always_comb begin
    idle = !wr_en_q;
    for (int i = 0; i < LANES; i++) begin
      if (count_q[i] != '0) begin
        idle = 1'b0;
      end
    end
  end

  assign bus.res_ready = ready;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.busy      = busy;
  assign bus.idle      = idle;

endmodule
